// File: rtl/rr_mux_sel_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_sel_ctrl_if
// Brief    : Request/grant bundle between two requesters and the mux arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface rr_mux_sel_ctrl_if #(
    parameter int CNT_W = 3
);
    logic             req0;
    logic             req1;
    logic             sel;
    logic             en;
    logic             gnt0;
    logic             gnt1;
    logic [CNT_W-1:0] hold_cnt;

    // Requester side drives requests and observes grants.
    modport master (
        output req0, req1,
        input  sel, en, gnt0, gnt1, hold_cnt
    );

    // Arbiter side.
    modport slave (
        input  req0, req1,
        output sel, en, gnt0, gnt1, hold_cnt
    );
endinterface
`default_nettype wire

// File: rtl/rr_mux_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_sel_ctrl
// Brief    : Two-requester burst-limited round-robin arbiter driving mux sel/en.
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux_sel_ctrl #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  wire logic         clk,
    input  wire logic         rst,
    rr_mux_sel_ctrl_if.slave  bus
);

    localparam logic [1:0]       c_IDLE      = 2'd0;
    localparam logic [1:0]       c_G0        = 2'd1;
    localparam logic [1:0]       c_G1        = 2'd2;
    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_last_gnt;
    logic             r_sel;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_last_nxt;
    logic             w_sel_nxt;
    logic             w_en;
    logic             w_gnt0;
    logic             w_gnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_hold_cnt <= '0;
            r_last_gnt <= 1'b1;
            r_sel      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_cnt_nxt;
            r_last_gnt <= w_last_nxt;
            r_sel      <= w_sel_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_last_nxt  = r_last_gnt;
        w_sel_nxt   = r_sel;
        case (r_state)
            c_IDLE: begin
                if (bus.req0 && bus.req1) begin
                    w_state_nxt = r_last_gnt ? c_G0 : c_G1;
                end else if (bus.req0) begin
                    w_state_nxt = c_G0;
                end else if (bus.req1) begin
                    w_state_nxt = c_G1;
                end else begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_G0: begin
                if (bus.req0 && r_hold_cnt != c_HOLD_LAST) begin
                    w_cnt_nxt = r_hold_cnt + c_CNT_ONE;
                end else if (bus.req1) begin
                    w_state_nxt = c_G1;
                end else if (!bus.req0) begin
                    w_state_nxt = c_IDLE;
                end
                // Otherwise the burst limit was hit with no competitor: stay, count wraps.
            end
            c_G1: begin
                if (bus.req1 && r_hold_cnt != c_HOLD_LAST) begin
                    w_cnt_nxt = r_hold_cnt + c_CNT_ONE;
                end else if (bus.req0) begin
                    w_state_nxt = c_G0;
                end else if (!bus.req1) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase

        // A fresh grant records its owner and points the mux at it.
        if (w_state_nxt != r_state && w_state_nxt != c_IDLE) begin
            w_cnt_nxt  = '0;
            w_last_nxt = (w_state_nxt == c_G1);
            w_sel_nxt  = (w_state_nxt == c_G1);
        end
    end

    always_comb begin
        w_en   = (r_state == c_G0) || (r_state == c_G1);
        w_gnt0 = (r_state == c_G0);
        w_gnt1 = (r_state == c_G1);
    end

    assign bus.en       = w_en;
    assign bus.gnt0     = w_gnt0;
    assign bus.gnt1     = w_gnt1;
    assign bus.sel      = r_sel;
    assign bus.hold_cnt = r_hold_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_sel_ctrl
// Brief    : Self-checking bench for rr_mux_sel_ctrl against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_sel_ctrl;
    localparam int MAX_HOLD = 4;
    localparam int CNT_W    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    rr_mux_sel_ctrl_if #(.CNT_W(CNT_W)) bus ();

    rr_mux_sel_ctrl #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, int act, int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model: owner -1 = nobody, else index of the granted requester.
    int m_own   = -1;
    int m_cnt   = 0;
    int m_last  = 1;
    int m_sel   = 0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin : model
        int  nown;
        bit  mine;
        bit  other;
        if (rst) begin
            m_own = -1; m_cnt = 0; m_last = 1; m_sel = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_own < 0) begin
                if (bus.req0 && bus.req1) nown = 1 - m_last;
                else if (bus.req0)        nown = 0;
                else if (bus.req1)        nown = 1;
                else                      nown = -1;
            end else begin
                mine  = (m_own == 0) ? bus.req0 : bus.req1;
                other = (m_own == 0) ? bus.req1 : bus.req0;
                if (mine && !(other && m_cnt == MAX_HOLD - 1)) nown = m_own;
                else if (other)                               nown = 1 - m_own;
                else                                          nown = -1;
            end
            if (nown < 0 || nown != m_own) m_cnt = 0;
            else                           m_cnt = (m_cnt + 1) % MAX_HOLD;
            if (nown >= 0 && nown != m_own) begin
                m_last = nown;
                m_sel  = nown;
            end
            m_own = nown;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("sel",      int'(bus.sel),      m_sel);
            chk("en",       int'(bus.en),       int'(m_own >= 0));
            chk("gnt0",     int'(bus.gnt0),     int'(m_own == 0));
            chk("gnt1",     int'(bus.gnt1),     int'(m_own == 1));
            chk("hold_cnt", int'(bus.hold_cnt), m_cnt);
            chk("onehot",   int'(bus.gnt0 && bus.gnt1), 0);
        end
    end

    task automatic step(input bit r, input bit q0, input bit q1);
        rst      = r;
        bus.req0 = q0;
        bus.req1 = q1;
        @(negedge clk);
    endtask

    task automatic expect_out(string nm, int s, int e, int g0, int g1, int c);
        chk({nm, ".sel"},  int'(bus.sel),      s);
        chk({nm, ".en"},   int'(bus.en),       e);
        chk({nm, ".gnt0"}, int'(bus.gnt0),     g0);
        chk({nm, ".gnt1"}, int'(bus.gnt1),     g1);
        chk({nm, ".cnt"},  int'(bus.hold_cnt), c);
    endtask

    initial begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;

        // Reset held with both requesting
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b1);
            expect_out("reset", 0, 0, 0, 0, 0);
        end
        chk("model_last_after_reset", m_last, 1);

        // Single requester for three cycles
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            expect_out("single", 0, 1, 1, 0, i);
        end
        step(1'b0, 1'b0, 1'b0);
        expect_out("single_idle", 0, 0, 0, 0, 0);

        // Contention from a fresh reset
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b1);
            expect_out("contend", (i / 4) % 2, 1, int'((i / 4) % 2 == 0),
                       int'((i / 4) % 2 == 1), i % 4);
        end

        // req1 alone: direct handover from G0, then burst wrap
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1);
            expect_out("wrap", 1, 1, 0, 1, i % 4);
        end
        chk("model_cnt_after_wrap", m_cnt, 1);

        // Early release from G0 at hold_cnt=1
        step(1'b0, 1'b0, 1'b0);
        expect_out("rel_idle", 1, 0, 0, 0, 0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        expect_out("rel_g0", 0, 1, 1, 0, 1);
        step(1'b0, 1'b0, 1'b1);
        expect_out("rel_g1", 1, 1, 0, 1, 0);

        // Reset in the middle of a G1 burst
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        expect_out("mid_g1", 1, 1, 0, 1, 2);
        step(1'b1, 1'b1, 1'b1);
        expect_out("mid_rst", 0, 0, 0, 0, 0);
        step(1'b0, 1'b1, 1'b1);
        expect_out("post_rst", 0, 1, 1, 0, 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom));
        end

        step(1'b0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
